// File: rtl/sync_debounce_bank.sv
// Multi-channel input synchroniser with optional per-channel debounce filter and edge pulses.
// Define DEBOUNCE_FILTER_EN to build the stability counters; otherwise the output follows the synchroniser directly.
module sync_debounce_bank #(
  parameter int                WIDTH        = 4,
  parameter int                STAGES       = 2,
  parameter int                DEBOUNCE_CNT = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk_dst,
  input  logic             rst_dst,
  input  logic [WIDTH-1:0] signal_src,
  output logic [WIDTH-1:0] signal_dst,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  always_comb begin
    sync_d[0] = signal_src;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s_last = sync_q[STAGES-1];

`ifdef DEBOUNCE_FILTER_EN
  localparam int             CW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  // A channel's counter only runs while s_last disagrees with its output; any agreement restarts it.
  always_comb begin
    dst_d = dst_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(1);
      if (s_last[i] == dst_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        dst_d[i] = s_last[i];
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign dst_d = s_last;

  // Filter depth has no meaning without the counters.
  logic [31:0] unused_debounce_cnt;
  assign unused_debounce_cnt = 32'(DEBOUNCE_CNT);
`endif

  assign rise_d = ~dst_q & dst_d;
  assign fall_d = dst_q & ~dst_d;
  assign any_d  = |(rise_d | fall_d);

  // Pulses are registered alongside the level so they coincide with the output toggle.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
      dst_q  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= sync_d[k];
      dst_q  <= dst_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign signal_dst = dst_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank; expectations follow whichever build (filter on/off) is compiled.
module tb_sync_debounce_bank;

`ifdef DEBOUNCE_FILTER_EN
  localparam int ST  = 2;
  localparam int EFF = 16;
  localparam int PRE = ST + 12;
`else
  localparam int ST  = 3;
  localparam int EFF = 1;
  localparam int PRE = 1;
`endif
  localparam int LAT = ST + EFF;

  logic       clk_dst;
  logic       rst_dst;
  logic [3:0] signal_src;
  logic [3:0] signal_dst;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       any_change;

  int tests_run;
  int tests_failed;

  sync_debounce_bank #(
    .WIDTH(4), .STAGES(ST), .DEBOUNCE_CNT(16), .RESET_VAL(4'b0000)
  ) dut (
    .clk_dst(clk_dst), .rst_dst(rst_dst), .signal_src(signal_src),
    .signal_dst(signal_dst), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  initial clk_dst = 1'b0;
  always #5 clk_dst = ~clk_dst;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_dst);
    rst_dst    = 1'b1;
    signal_src = 4'b0000;
    repeat (2) @(negedge clk_dst);
    rst_dst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_dst);
    rst_dst    = 1'b1;
    signal_src = 4'hF;
    repeat (3) @(negedge clk_dst);
    tests_run++;
    if (signal_dst !== 4'b0000) begin tests_failed++; $display("FAIL rst_dst_level got %b want 0000", signal_dst); end
    tests_run++;
    if (rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000 || any_change !== 1'b0) begin
      tests_failed++; $display("FAIL rst_pulses got r=%b f=%b a=%b want 0", rise_pulse, fall_pulse, any_change);
    end
    rst_dst = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (e < LAT && (signal_dst !== 4'b0000 || rise_pulse !== 4'b0000 || any_change !== 1'b0)) begin
        tests_failed++; $display("FAIL rst_release e=%0d got d=%b r=%b a=%b want 0", e, signal_dst, rise_pulse, any_change);
      end
      if (e == LAT && (signal_dst !== 4'hF || rise_pulse !== 4'hF || any_change !== 1'b1)) begin
        tests_failed++; $display("FAIL rst_release_rise got d=%b r=%b a=%b want 1111/1111/1", signal_dst, rise_pulse, any_change);
      end
    end
    do_reset();
  endtask

  task automatic test_latency();
    signal_src = 4'b0001;
    for (int e = 1; e <= LAT + 2; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (signal_dst !== ((e >= LAT) ? 4'b0001 : 4'b0000) || rise_pulse !== ((e == LAT) ? 4'b0001 : 4'b0000)
          || fall_pulse !== 4'b0000 || any_change !== (e == LAT)) begin
        tests_failed++;
        $display("FAIL latency_rise e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
    signal_src = 4'b0000;
    for (int e = 1; e <= LAT + 2; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (signal_dst !== ((e >= LAT) ? 4'b0000 : 4'b0001) || fall_pulse !== ((e == LAT) ? 4'b0001 : 4'b0000)
          || rise_pulse !== 4'b0000 || any_change !== (e == LAT)) begin
        tests_failed++;
        $display("FAIL latency_fall e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
  endtask

`ifdef DEBOUNCE_FILTER_EN
  task automatic test_glitch();
    int rises;
    signal_src = 4'b0010;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk_dst);
      if (e == 10) signal_src = 4'b0000;
      tests_run++;
      if (signal_dst !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000 || any_change !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch_reject e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
    rises = 0;
    signal_src = 4'b0010;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk_dst);
      if (e == 16) signal_src = 4'b0000;
      if (rise_pulse[1]) rises++;
      if (e == 18) begin
        tests_run++;
        if (rise_pulse !== 4'b0010 || signal_dst !== 4'b0010) begin
          tests_failed++; $display("FAIL glitch_accept_edge got d=%b r=%b want 0010/0010", signal_dst, rise_pulse);
        end
      end
      if (e == 34) begin
        tests_run++;
        if (fall_pulse !== 4'b0010 || signal_dst !== 4'b0000) begin
          tests_failed++; $display("FAIL glitch_accept_fall got d=%b f=%b want 0000/0010", signal_dst, fall_pulse);
        end
      end
    end
    tests_run++;
    if (rises != 1) begin tests_failed++; $display("FAIL glitch_accept_count got %0d want 1", rises); end
  endtask
`else
  task automatic test_macro_off();
    signal_src = 4'b0100;
    @(negedge clk_dst);
    signal_src = 4'b0000;
    tests_run++;
    if (signal_dst !== 4'b0000) begin tests_failed++; $display("FAIL pulse_pass e=1 got d=%b want 0000", signal_dst); end
    for (int e = 2; e <= LAT + 3; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (signal_dst !== ((e == LAT) ? 4'b0100 : 4'b0000) || rise_pulse !== ((e == LAT) ? 4'b0100 : 4'b0000)
          || fall_pulse !== ((e == LAT + 1) ? 4'b0100 : 4'b0000) || any_change !== (e == LAT || e == LAT + 1)) begin
        tests_failed++;
        $display("FAIL pulse_pass e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
  endtask
`endif

  task automatic test_multi_channel();
    signal_src = 4'b1010;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (signal_dst !== ((e >= LAT) ? 4'b1010 : 4'b0000) || rise_pulse !== ((e == LAT) ? 4'b1010 : 4'b0000)
          || fall_pulse !== 4'b0000 || any_change !== (e == LAT)) begin
        tests_failed++;
        $display("FAIL multi_rise e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
    signal_src = 4'b0000;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (signal_dst !== ((e >= LAT) ? 4'b0000 : 4'b1010) || fall_pulse !== ((e == LAT) ? 4'b1010 : 4'b0000)
          || rise_pulse !== 4'b0000 || any_change !== (e == LAT)) begin
        tests_failed++;
        $display("FAIL multi_fall e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
  endtask

  task automatic test_independent();
    signal_src = 4'b0100;
    @(negedge clk_dst);
    signal_src = 4'b1100;
    for (int e = 2; e <= LAT + 2; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (rise_pulse !== ((e == LAT) ? 4'b0100 : (e == LAT + 1) ? 4'b1000 : 4'b0000)
          || any_change !== (e == LAT || e == LAT + 1)) begin
        tests_failed++;
        $display("FAIL independent e=%0d got r=%b a=%b", e, rise_pulse, any_change);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_count();
    signal_src = 4'b1000;
    repeat (LAT + 1) @(negedge clk_dst);
    tests_run++;
    if (signal_dst !== 4'b1000) begin tests_failed++; $display("FAIL midrst_setup got %b want 1000", signal_dst); end
    signal_src = 4'b1001;
    repeat (PRE) @(negedge clk_dst);
    tests_run++;
    if (signal_dst !== 4'b1000) begin tests_failed++; $display("FAIL midrst_pending got %b want 1000", signal_dst); end
    rst_dst = 1'b1;
    #1;
    tests_run++;
    if (signal_dst !== 4'b0000 || fall_pulse !== 4'b0000 || any_change !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_async got d=%b f=%b a=%b want 0", signal_dst, fall_pulse, any_change);
    end
    repeat (2) @(negedge clk_dst);
    rst_dst = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge clk_dst);
      tests_run++;
      if (signal_dst !== ((e >= LAT) ? 4'b1001 : 4'b0000) || rise_pulse !== ((e == LAT) ? 4'b1001 : 4'b0000)
          || fall_pulse !== 4'b0000 || any_change !== (e == LAT)) begin
        tests_failed++;
        $display("FAIL midrst_release e=%0d got d=%b r=%b f=%b a=%b", e, signal_dst, rise_pulse, fall_pulse, any_change);
      end
    end
    do_reset();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_dst      = 1'b1;
    signal_src   = 4'b0000;
    test_reset();
    test_latency();
`ifdef DEBOUNCE_FILTER_EN
    test_glitch();
`else
    test_macro_off();
`endif
    test_multi_channel();
    test_independent();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
